branch_predict_pc: RTL and testbench

Fetch-side next-PC generator with a gshare direction predictor. It sits directly upstream of the instruction queue and consumes the branch unit's resolution port (`o_pc_*`). It holds the fetch PC, predicts the next PC from predecoded fetch information, and snapshots the global history into each queue entry. On branch resolution it trains the pattern history table and, on a misprediction, redirects the PC and restores the history.

---
 rtl/branch_predict_pc.sv | 112 +++++++++++
 tb/tb_branch_predict_pc.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_pc.sv
// Fetch-side next-PC generator: holds the fetch PC, predicts the next PC with a
// gshare pattern history table, and trains/redirects on branch resolution.
module branch_predict_pc #(
  parameter int                    BW_ADDRESS         = 32,
  parameter int                    NUM_GLOBAL_HISTORY = 4,
  parameter logic [BW_ADDRESS-1:0] RESET_PC           = '0,
  parameter int                    BW_MISS_CNT        = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic [BW_ADDRESS-1:0]         o_fetch_pc,
  input  logic                          i_fetch_valid,
  input  logic                          i_fetch_is_cond,
  input  logic                          i_fetch_is_jal,
  input  logic [BW_ADDRESS-1:0]         i_fetch_imm,
  output logic                          o_iq_valid,
  input  logic                          i_iq_ready,
  output logic [BW_ADDRESS-1:0]         o_iq_PC,
  output logic [BW_ADDRESS-1:0]         o_iq_PC_next,
  output logic [NUM_GLOBAL_HISTORY-1:0] o_iq_global_history,
  input  logic                          i_bu_valid,
  input  logic [BW_ADDRESS-1:0]         i_bu_pc,
  input  logic [BW_ADDRESS-1:0]         i_bu_correct_pc_next,
  input  logic [NUM_GLOBAL_HISTORY-1:0] i_bu_global_history,
  input  logic                          i_bu_correct_prediction,
  output logic [BW_MISS_CNT-1:0]        o_miss_count
);

  localparam int                     H        = NUM_GLOBAL_HISTORY;
  localparam int                     PHT_SIZE = 1 << H;
  localparam logic [BW_ADDRESS-1:0]  PC_STEP  = 4;
  localparam logic [BW_MISS_CNT-1:0] MISS_ONE = 1;

  typedef enum logic {RUN, BUBBLE} state_t;

  state_t                 state, state_next;
  logic [BW_ADDRESS-1:0]  pc_q;
  logic [H-1:0]           ghr_q;
  logic [1:0]             pht [PHT_SIZE];
  logic [BW_MISS_CNT-1:0] miss_q;

  logic [H-1:0]          fetch_idx, bu_idx;
  logic                  cond_taken, pred_taken, bu_taken;
  logic                  redirect, handshake;
  logic [BW_ADDRESS-1:0] pc_pred;

  assign fetch_idx  = pc_q[2 +: H] ^ ghr_q;
  assign cond_taken = pht[fetch_idx][1];
  assign pred_taken = i_fetch_is_jal || (i_fetch_is_cond && cond_taken);
  assign pc_pred    = pred_taken ? (pc_q + i_fetch_imm) : (pc_q + PC_STEP);

  assign bu_idx     = i_bu_pc[2 +: H] ^ i_bu_global_history;
  assign bu_taken   = (i_bu_correct_pc_next != (i_bu_pc + PC_STEP));
  assign redirect   = i_bu_valid && !i_bu_correct_prediction;

  // A mispredict in flight blocks this cycle's entry so the queue never sees a wrong-path handshake.
  assign o_iq_valid = !rst && i_fetch_valid && (state == RUN) && !redirect;
  assign handshake  = o_iq_valid && i_iq_ready;

  assign o_fetch_pc          = pc_q;
  assign o_iq_PC             = pc_q;
  assign o_iq_PC_next        = pc_pred;
  assign o_iq_global_history = ghr_q;
  assign o_miss_count        = miss_q;

  always_comb begin
    state_next = state;
    if (redirect)
      state_next = BUBBLE;
    else if (state == BUBBLE)
      state_next = RUN;
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= RUN;
    else
      state <= state_next;
  end

  // Redirect wins over a same-cycle handshake; training happens on every resolution.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      ghr_q  <= '0;
      miss_q <= '0;
      for (int i = 0; i < PHT_SIZE; i++)
        pht[i] <= 2'b01;
    end else begin
      if (i_bu_valid) begin
        if (bu_taken) begin
          if (pht[bu_idx] != 2'b11)
            pht[bu_idx] <= pht[bu_idx] + 2'b01;
        end else begin
          if (pht[bu_idx] != 2'b00)
            pht[bu_idx] <= pht[bu_idx] - 2'b01;
        end
      end
      if (redirect) begin
        pc_q  <= i_bu_correct_pc_next;
        ghr_q <= {i_bu_global_history[H-2:0], bu_taken};
        if (miss_q != '1)
          miss_q <= miss_q + MISS_ONE;
      end else if (handshake) begin
        pc_q <= pc_pred;
        if (i_fetch_is_cond)
          ghr_q <= {ghr_q[H-2:0], cond_taken};
      end
    end
  end

endmodule

// File: tb/tb_branch_predict_pc.sv
// Directed bench for branch_predict_pc: sequential fetch, backpressure, gshare
// training/saturation, redirects (single, double, during reset).
module tb_branch_predict_pc;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] o_fetch_pc;
  logic        i_fetch_valid, i_fetch_is_cond, i_fetch_is_jal;
  logic [31:0] i_fetch_imm;
  logic        o_iq_valid, i_iq_ready;
  logic [31:0] o_iq_PC, o_iq_PC_next;
  logic [3:0]  o_iq_global_history;
  logic        i_bu_valid;
  logic [31:0] i_bu_pc, i_bu_correct_pc_next;
  logic [3:0]  i_bu_global_history;
  logic        i_bu_correct_prediction;
  logic [15:0] o_miss_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_predict_pc #(
    .BW_ADDRESS(32), .NUM_GLOBAL_HISTORY(4), .RESET_PC(32'h100), .BW_MISS_CNT(16)
  ) dut (
    .clk(clk), .rst(rst), .o_fetch_pc(o_fetch_pc),
    .i_fetch_valid(i_fetch_valid), .i_fetch_is_cond(i_fetch_is_cond),
    .i_fetch_is_jal(i_fetch_is_jal), .i_fetch_imm(i_fetch_imm),
    .o_iq_valid(o_iq_valid), .i_iq_ready(i_iq_ready),
    .o_iq_PC(o_iq_PC), .o_iq_PC_next(o_iq_PC_next),
    .o_iq_global_history(o_iq_global_history),
    .i_bu_valid(i_bu_valid), .i_bu_pc(i_bu_pc),
    .i_bu_correct_pc_next(i_bu_correct_pc_next),
    .i_bu_global_history(i_bu_global_history),
    .i_bu_correct_prediction(i_bu_correct_prediction),
    .o_miss_count(o_miss_count)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Drives fetch/queue inputs and the resolution port, then lets outputs settle.
  task automatic applyStimulus(input logic fv, input logic cond, input logic jal,
                               input logic [31:0] imm, input logic rdy,
                               input logic buv, input logic [31:0] bupc,
                               input logic [31:0] bunext, input logic [3:0] buhist,
                               input logic bucorr);
    i_fetch_valid           = fv;
    i_fetch_is_cond         = cond;
    i_fetch_is_jal          = jal;
    i_fetch_imm             = imm;
    i_iq_ready              = rdy;
    i_bu_valid              = buv;
    i_bu_pc                 = bupc;
    i_bu_correct_pc_next    = bunext;
    i_bu_global_history     = buhist;
    i_bu_correct_prediction = bucorr;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1, 0, 0, 0, 1, 0, 0, 0, 4'h0, 1);
    cycle();
    cycle();
    checkOutput("rst_valid", o_iq_valid, 0);
    checkOutput("rst_pc", o_fetch_pc, 32'h100);
    checkOutput("rst_miss", o_miss_count, 0);

    // Sequential fetch
    rst = 1'b0;
    applyStimulus(1, 0, 0, 0, 1, 0, 0, 0, 4'h0, 1);
    checkOutput("seq0_valid", o_iq_valid, 1);
    checkOutput("seq0_pc", o_iq_PC, 32'h100);
    checkOutput("seq0_next", o_iq_PC_next, 32'h104);
    checkOutput("seq0_ghr", o_iq_global_history, 0);
    cycle();
    checkOutput("seq1_pc", o_iq_PC, 32'h104);

    // Backpressure at 0x104
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 4'h0, 1);
      checkOutput("bp_fetch_pc", o_fetch_pc, 32'h104);
      checkOutput("bp_next", o_iq_PC_next, 32'h108);
      checkOutput("bp_valid", o_iq_valid, 1);
      cycle();
    end
    applyStimulus(1, 0, 0, 0, 1, 0, 0, 0, 4'h0, 1);
    checkOutput("bp_hold_pc", o_iq_PC, 32'h104);
    cycle();
    applyStimulus(1, 0, 1, 32'hF8, 1, 0, 0, 0, 4'h0, 1);
    checkOutput("seq2_pc", o_iq_PC, 32'h108);
    checkOutput("jal_fwd_next", o_iq_PC_next, 32'h200);
    cycle();

    // Untrained conditional at 0x200
    applyStimulus(1, 1, 0, 32'h40, 1, 0, 0, 0, 4'h0, 1);
    checkOutput("cond_untrained_next", o_iq_PC_next, 32'h204);
    cycle();
    applyStimulus(1, 0, 1, 32'hFC, 1, 0, 0, 0, 4'h0, 1);
    checkOutput("cond_ghr_shift0", o_iq_global_history, 0);
    checkOutput("at_204", o_iq_PC, 32'h204);
    cycle();
    applyStimulus(1, 0, 1, 32'hFFFF_FFF8, 1, 0, 0, 0, 4'h0, 1);
    checkOutput("jal_back_next", o_iq_PC_next, 32'h2F8);
    cycle();

    // Training 01->10 with a concurrent handshake, then 10->11
    applyStimulus(1, 0, 0, 0, 1, 1, 32'h200, 32'h240, 4'h0, 1);
    checkOutput("train_no_block", o_iq_valid, 1);
    checkOutput("at_2f8", o_iq_PC, 32'h2F8);
    cycle();
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h200, 32'h240, 4'h0, 1);
    checkOutput("fetch_idle_valid", o_iq_valid, 0);
    cycle();
    applyStimulus(1, 0, 1, 32'hFFFF_FF04, 1, 0, 0, 0, 4'h0, 1);
    checkOutput("at_2fc", o_iq_PC, 32'h2FC);
    cycle();
    applyStimulus(1, 1, 0, 32'h40, 1, 0, 0, 0, 4'h0, 1);
    checkOutput("cond_trained_next", o_iq_PC_next, 32'h240);
    cycle();
    applyStimulus(1, 0, 0, 0, 1, 0, 0, 0, 4'h0, 1);
    checkOutput("cond_ghr_shift1", o_iq_global_history, 4'b0001);
    checkOutput("at_240", o_iq_PC, 32'h240);

    // Redirect while the queue would accept
    applyStimulus(1, 0, 0, 0, 1, 1, 32'h200, 32'h240, 4'b0011, 0);
    checkOutput("redir_blocks_valid", o_iq_valid, 0);
    cycle();
    applyStimulus(1, 0, 0, 0, 1, 0, 0, 0, 4'h0, 1);
    checkOutput("redir_pc", o_fetch_pc, 32'h240);
    checkOutput("redir_ghr", o_iq_global_history, 4'b0111);
    checkOutput("redir_bubble", o_iq_valid, 0);
    checkOutput("redir_miss", o_miss_count, 1);
    cycle();
    applyStimulus(1, 0, 1, 32'h1C, 1, 0, 0, 0, 4'h0, 1);
    checkOutput("redir_resume", o_iq_valid, 1);
    cycle();

    // Saturation probe: cond fetch at 0x25C with GHR 0111 indexes PHT[0]
    applyStimulus(1, 1, 0, 32'h40, 0, 1, 32'h200, 32'h240, 4'h0, 1);
    checkOutput("probe_pc", o_fetch_pc, 32'h25C);
    checkOutput("probe_pre_sat", o_iq_PC_next, 32'h29C);
    cycle();
    applyStimulus(1, 1, 0, 32'h40, 0, 0, 0, 0, 4'h0, 1);
    checkOutput("sat_high", o_iq_PC_next, 32'h29C);
    for (int i = 0; i < 4; i++) begin
      cycle();
      applyStimulus(1, 1, 0, 32'h40, 0, 1, 32'h200, 32'h204, 4'h0, 1);
    end
    cycle();
    applyStimulus(1, 1, 0, 32'h40, 0, 0, 0, 0, 4'h0, 1);
    checkOutput("sat_low", o_iq_PC_next, 32'h260);
    applyStimulus(1, 1, 0, 32'h40, 0, 1, 32'h200, 32'h240, 4'h0, 1);
    cycle();
    applyStimulus(1, 1, 0, 32'h40, 0, 0, 0, 0, 4'h0, 1);
    checkOutput("ctr_01_not_taken", o_iq_PC_next, 32'h260);
    applyStimulus(1, 1, 0, 32'h40, 0, 1, 32'h200, 32'h240, 4'h0, 1);
    cycle();
    applyStimulus(1, 1, 0, 32'h40, 0, 0, 0, 0, 4'h0, 1);
    checkOutput("ctr_10_taken", o_iq_PC_next, 32'h29C);

    // Double redirect: second one lands during BUBBLE
    applyStimulus(1, 0, 0, 0, 1, 1, 32'h400, 32'h500, 4'h0, 0);
    checkOutput("dbl1_valid", o_iq_valid, 0);
    cycle();
    applyStimulus(1, 0, 0, 0, 1, 1, 32'h500, 32'h504, 4'b0010, 0);
    checkOutput("dbl1_pc", o_fetch_pc, 32'h500);
    checkOutput("dbl1_bubble", o_iq_valid, 0);
    checkOutput("dbl1_miss", o_miss_count, 2);
    checkOutput("dbl1_ghr", o_iq_global_history, 4'b0001);
    cycle();
    applyStimulus(1, 0, 0, 0, 1, 0, 0, 0, 4'h0, 1);
    checkOutput("dbl2_pc", o_fetch_pc, 32'h504);
    checkOutput("dbl2_bubble_ext", o_iq_valid, 0);
    checkOutput("dbl2_miss", o_miss_count, 3);
    checkOutput("dbl2_ghr", o_iq_global_history, 4'b0100);
    cycle();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 4'h0, 1);
    checkOutput("dbl_resume", o_iq_valid, 1);
    checkOutput("dbl_resume_next", o_iq_PC_next, 32'h508);

    // Reset during a bubble discards it and clears the PHT
    applyStimulus(1, 0, 0, 0, 0, 1, 32'h700, 32'h600, 4'h0, 0);
    cycle();
    rst = 1'b1;
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 4'h0, 1);
    checkOutput("mid_rst_valid", o_iq_valid, 0);
    cycle();
    rst = 1'b0;
    applyStimulus(1, 1, 0, 32'h40, 0, 0, 0, 0, 4'h0, 1);
    checkOutput("post_rst_valid", o_iq_valid, 1);
    checkOutput("post_rst_pc", o_fetch_pc, 32'h100);
    checkOutput("post_rst_miss", o_miss_count, 0);
    checkOutput("post_rst_ghr", o_iq_global_history, 0);
    checkOutput("post_rst_pht", o_iq_PC_next, 32'h104);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
